// File: rtl/hamming_secded_encoder_pkg.sv
// hamming_pkg: Hamming/SECDED helper functions and buffer state type, shared with the decoder.
// Rev 1.0
`default_nettype none

package hamming_pkg;

  localparam int MAX_CODE_W = 64;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_e;

  function automatic bit is_pow2(input int pos);
    return (pos > 0) && ((pos & (pos - 1)) == 0);
  endfunction

  function automatic int hamming_r(input int data_w);
    int r;
    r = 0;
    for (int i = 0; i < 7; i++) begin
      if ((1 << r) < data_w + r + 1) r++;
    end
    return r;
  endfunction

  function automatic int hamming_code_w(input int data_w, input bit secded);
    return data_w + hamming_r(data_w) + int'(secded);
  endfunction

  // Data fills non-power-of-two positions first; parity is then taken over those positions.
  function automatic logic [MAX_CODE_W-1:0] hamming_encode(input logic [MAX_CODE_W-1:0] data,
                                                           input int data_w,
                                                           input bit secded);
    int                    n;
    int                    di;
    logic                  par;
    logic [MAX_CODE_W-1:0] code;
    n    = data_w + hamming_r(data_w);
    code = '0;
    di   = 0;
    for (int p = 1; p < MAX_CODE_W; p++) begin
      if (p <= n && !is_pow2(p)) begin
        code[6'(p - 1)] = data[6'(di)];
        di++;
      end
    end
    for (int k = 0; k < 6; k++) begin
      par = 1'b0;
      for (int p = 1; p < MAX_CODE_W; p++) begin
        if (p <= n && !is_pow2(p) && (((p >> k) & 1) == 1)) par = par ^ code[6'(p - 1)];
      end
      if ((1 << k) <= n) code[6'((1 << k) - 1)] = par;
    end
    if (secded) code[6'(n)] = ^code;
    return code;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hamming_secded_encoder_if.sv
// hamming_secded_encoder_if: data-in / code-out handshake bundle plus transfer counter.
// Rev 1.0
`default_nettype none

interface hamming_secded_encoder_if #(
  parameter int DATA_W = 4,
  parameter int CODE_W = 8,
  parameter int CNT_W  = 16
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [CODE_W-1:0] out_code;
  logic              out_valid;
  logic              out_ready;
  logic [CNT_W-1:0]  code_cnt;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_code, out_valid, code_cnt
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_code, out_valid, code_cnt
  );
endinterface

`default_nettype wire

// File: rtl/hamming_secded_encoder_skid_buffer.sv
// hamming_skid_buffer: 2-entry out/skid register with valid/ready, registered in_ready and enable.
// Rev 1.0
`default_nettype none

module hamming_skid_buffer
  import hamming_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             ena_i,
  input  wire logic [WIDTH-1:0] in_data_i,
  input  wire logic             in_valid_i,
  output logic                  in_ready_o,
  output logic [WIDTH-1:0]      out_data_o,
  output logic                  out_valid_o,
  input  wire logic             out_ready_i
);

  buf_state_e       state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             rdy_q, rdy_d;
  logic             accept;
  logic             xfer;

  assign in_ready_o  = rdy_q & ena_i;
  assign out_valid_o = (state_q != BUF_EMPTY) & ena_i;
  assign out_data_o  = out_q;
  assign accept      = in_valid_i & in_ready_o;
  assign xfer        = out_valid_o & out_ready_i;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    case (state_q)
      BUF_EMPTY: begin
        if (accept) begin
          out_d   = in_data_i;
          state_d = BUF_ONE;
        end
      end
      BUF_ONE: begin
        if (accept && xfer) begin
          out_d = in_data_i;
        end else if (accept) begin
          skid_d  = in_data_i;
          state_d = BUF_FULL;
        end else if (xfer) begin
          state_d = BUF_EMPTY;
        end
      end
      BUF_FULL: begin
        if (xfer) begin
          out_d   = skid_q;
          state_d = BUF_ONE;
        end
      end
      default: state_d = BUF_EMPTY;
    endcase
  end

  // in_ready is a function of the next occupancy only, keeping it off the out_ready path.
  assign rdy_d = (state_d != BUF_FULL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BUF_EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
      rdy_q   <= 1'b0;
    end else if (ena_i) begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
      rdy_q   <= rdy_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/hamming_secded_encoder.sv
// hamming_secded_encoder: combinational Hamming/SECDED encode into a 2-entry skid buffer, with transfer counter.
// Rev 1.0
`default_nettype none

module hamming_secded_encoder
  import hamming_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int SECDED = 1,
  parameter int CNT_W  = 16
) (
  input  wire logic                clk,
  input  wire logic                rst_n,
  input  wire logic                ena,
  hamming_secded_encoder_if.slave  bus
);

  localparam int R      = hamming_r(DATA_W);
  localparam int CODE_W = DATA_W + R + SECDED;

  logic [CODE_W-1:0] enc_code;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              xfer;

  assign enc_code = CODE_W'(hamming_encode(MAX_CODE_W'(bus.in_data), DATA_W, SECDED != 0));

  hamming_skid_buffer #(
    .WIDTH (CODE_W)
  ) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena_i       (ena),
    .in_data_i   (enc_code),
    .in_valid_i  (bus.in_valid),
    .in_ready_o  (bus.in_ready),
    .out_data_o  (bus.out_code),
    .out_valid_o (bus.out_valid),
    .out_ready_i (bus.out_ready)
  );

  assign xfer  = bus.out_valid & bus.out_ready;
  assign cnt_d = xfer ? cnt_q + 1'b1 : cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.code_cnt = cnt_q;

endmodule

`default_nettype wire

// File: doc/hamming_secded_encoder.md
Name: hamming_secded_encoder

Overview:
Parametrised Hamming encoder for DATA_W-bit words, with an optional overall-parity bit for SECDED.
- Adds valid/ready handshakes on input and output, with a 2-entry output buffer.
- Keeps in_ready registered, so upstream timing does not depend on the downstream ready path.
- Counts transmitted codewords.
- Sits between the UART byte/nibble framing logic and the transmitter, replacing the fixed 4-bit encoder.

Parameters:
- DATA_W, 4, data bits per word; legal range 1..57.
- SECDED, 1, 1 = append overall parity as MSB; 0 = plain Hamming.
- CNT_W, 16, width of the codeword counter.
- Derived (localparam): R = smallest integer with 2^R >= DATA_W+R+1; CODE_W = DATA_W+R+SECDED.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ena  in  1  global enable; low freezes all state.
- in_data  in  DATA_W  data word; bit 0 is d0.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block can accept a word; registered.
- out_code  out  CODE_W  codeword.
- out_valid  out  1  out_code valid.
- out_ready  in  1  downstream accepts out_code.
- code_cnt  out  CNT_W  number of codewords transferred out; wraps.

Behaviour:
- Reset (async assert, sync release by the clk domain): out_code=0, out_valid=0, in_ready=0 during reset, code_cnt=0, both buffer entries empty.
  - in_ready rises on the first clock edge after release.
- Codeword layout:
  - Hamming positions 1..DATA_W+R; out_code[p-1] holds position p.
  - Parity bits sit at power-of-two positions.
  - Data bits d0, d1, ... fill the remaining positions in ascending order.
  - Parity at position 2^k = XOR of all data positions whose index has bit k set (even parity).
  - SECDED=1: out_code[CODE_W-1] = XOR of all lower CODE_W-1 bits.
- Transfer rules:
  - Input accepted when in_valid & in_ready.
  - Output transferred when out_valid & out_ready & ena.
- Enable:
  - in_ready = ena & ~skid_vld & ~rst.
  - out_valid = out_vld & ena.
  - ena low: no state changes.
- Buffer: out register (out_vld) plus skid register (skid_vld); encoding is done combinationally before capture.
  - States: EMPTY (neither valid), ONE (out_vld only), FULL (both valid).
  - EMPTY + accept -> ONE; codeword in out register next cycle (latency 1).
  - ONE + accept + out transfer -> ONE; new word replaces out.
  - ONE + accept, no out transfer -> FULL; new word captured in skid; in_ready low next cycle.
  - ONE + out transfer, no accept -> EMPTY.
  - FULL + out transfer -> ONE; skid moves to out; in_ready high next cycle.
  - FULL: no accept is possible.
- Ordering: strict FIFO; no word is dropped or duplicated.
- out_code holds stable while out_valid & ~out_ready.
- code_cnt:
  - Increments by 1 on each output transfer.
  - Wraps from 2^CNT_W-1 to 0.
  - Simultaneous accept and transfer have no effect on the count beyond +1.
- Reset mid-operation: all buffered words are discarded, the counter clears, and out_valid drops immediately (async).
- in_data is sampled only on an accept; X on in_data while in_valid=0 must not propagate.

Decomposition:
- Package hamming_pkg:
  - Function hamming_r(data_w) returning R.
  - Function hamming_code_w(data_w, secded).
  - Function hamming_encode(data, data_w, secded) returning the codeword.
  - Function is_pow2(pos).
  - Shared with the future decoder.
- Sub-module: hamming_skid_buffer (WIDTH param; 2-entry out/skid register with valid/ready and ena).
- The encoder top instantiates the skid buffer and calls the package encode function.

Test Plan:
1. DATA_W=4, SECDED=1, out_ready=1: in_data 4'b1011 -> out_code 8'h55 one cycle after accept; 4'h0 -> 8'h00; 4'b0001 -> 8'h87; 4'hF -> 8'hFF; code_cnt=4.
2. DATA_W=11, SECDED=1: in_data 11'h7FF -> 16'hFFFF. Same with SECDED=0 -> 15'h7FFF.
3. Backpressure: out_ready=0, push words A, B.
   - in_ready drops the cycle after B is accepted; out_code=enc(A) held.
   - Raise out_ready -> A then B delivered in order, in_ready returns; code_cnt=2.
4. ena low with out_valid pending and in_valid=1: out_valid=0, in_ready=0, no counter change. Raise ena -> the pending word transfers unchanged.
5. CNT_W=4: 17 transfers -> code_cnt=1 (wrapped).
6. Assert rst_n low while FULL: out_valid=0 and code_cnt=0 immediately. After release, in_ready=1 and no stale word appears.
